// File: rtl/mips_dbus_pkg.sv
// rtl/mips_dbus_pkg.sv - shared state encoding, size codes and alignment helper for the data-bus bridge
package mips_dbus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } dbus_state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      return ((size == SZ_HALF) && addr_lo[0]) || ((size == SZ_WORD) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/dbus_strb_gen.sv
// rtl/dbus_strb_gen.sv - byte strobes and lane-replicated store data from size/address/data
module dbus_strb_gen
   import mips_dbus_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_data,
   output logic [3:0]  o_wstrb,
   output logic [31:0] o_wdata
);

   always_comb begin
      o_wstrb = 4'b1111;
      o_wdata = i_data;
      case (i_size)
         SZ_BYTE: begin
            o_wstrb = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_data[7:0]}};
         end
         SZ_HALF: begin
            o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
            o_wdata = {2{i_data[15:0]}};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dbus_bridge.sv
// rtl/dbus_bridge.sv - MM-stage data bus to SRAM-like split handshake bridge
// Optional alignment check enabled by defining DBUS_ALIGN_CHECK_EN.
module dbus_bridge
   import mips_dbus_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dbus_en,
   input  logic              dbus_we,
   input  logic [1:0]        dbus_size,
   input  logic [ADDR_W-1:0] dbus_addr,
   input  logic [DATA_W-1:0] dbus_data,
   input  logic              flush,
   input  logic              pipe_hold,
   output logic              dbus_stall,
   output logic [DATA_W-1:0] dbus_rdata,
   output logic              addr_err,
   output logic              sram_req,
   output logic              sram_wr,
   output logic [1:0]        sram_size,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [3:0]        sram_wstrb,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic              sram_addr_ok,
   input  logic              sram_data_ok,
   input  logic [DATA_W-1:0] sram_rdata
);

   dbus_state_e       r_state;
   dbus_state_e       w_state_nxt;
   logic              r_we;
   logic [1:0]        r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [3:0]        r_wstrb;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_discard;

   logic              w_capture;
   logic              w_latch;
   logic              w_discard_nxt;
   logic              w_addr_err;
   logic [3:0]        w_gen_strb;
   logic [DATA_W-1:0] w_gen_wdata;

   dbus_strb_gen u_strb_gen (
      .i_size    (dbus_size),
      .i_addr_lo (dbus_addr[1:0]),
      .i_data    (dbus_data),
      .o_wstrb   (w_gen_strb),
      .o_wdata   (w_gen_wdata)
   );

`ifdef DBUS_ALIGN_CHECK_EN
   assign w_addr_err = (r_state == IDLE) && dbus_en && is_misaligned(dbus_size, dbus_addr[1:0]);
`else
   assign w_addr_err = 1'b0;
`endif

   always_comb begin
      w_state_nxt   = r_state;
      w_capture     = 1'b0;
      w_latch       = 1'b0;
      w_discard_nxt = r_discard;
      case (r_state)
         IDLE: begin
            if (dbus_en && !flush && !w_addr_err) begin
               w_capture   = 1'b1;
               w_state_nxt = ADDR;
            end
         end
         ADDR: begin
            if (sram_addr_ok) begin
               if (sram_data_ok) begin
                  if (flush) begin
                     w_state_nxt = IDLE;
                  end else begin
                     w_latch     = 1'b1;
                     w_state_nxt = DONE;
                  end
               end else begin
                  // An accepted request must still be drained even if squashed.
                  w_state_nxt   = DATA;
                  w_discard_nxt = flush;
               end
            end else if (flush) begin
               w_state_nxt = IDLE;
            end
         end
         DATA: begin
            if (sram_data_ok) begin
               w_discard_nxt = 1'b0;
               if (r_discard || flush) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_latch     = 1'b1;
                  w_state_nxt = DONE;
               end
            end else if (flush) begin
               w_discard_nxt = 1'b1;
            end
         end
         DONE: begin
            if (!pipe_hold || flush) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_we      <= 1'b0;
         r_size    <= 2'b00;
         r_addr    <= '0;
         r_wstrb   <= 4'b0000;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_discard <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_discard <= w_discard_nxt;
         if (w_capture) begin
            r_we    <= dbus_we;
            r_size  <= dbus_size;
            r_addr  <= dbus_addr;
            r_wstrb <= dbus_we ? w_gen_strb : 4'b0000;
            r_wdata <= w_gen_wdata;
         end
         if (w_latch) r_rdata <= sram_rdata;
      end
   end

   assign dbus_stall = w_capture || (r_state == ADDR) || (r_state == DATA);
   assign dbus_rdata = r_rdata;
   assign addr_err   = w_addr_err;
   assign sram_req   = (r_state == ADDR);
   assign sram_wr    = r_we;
   assign sram_size  = r_size;
   assign sram_addr  = r_addr;
   assign sram_wstrb = r_wstrb;
   assign sram_wdata = r_wdata;

endmodule

// File: tb/tb_dbus_bridge.sv
// tb/tb_dbus_bridge.sv - directed and randomized self-checking bench for dbus_bridge
module tb_dbus_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dbus_en = 1'b0;
   logic        dbus_we = 1'b0;
   logic [1:0]  dbus_size = 2'b00;
   logic [31:0] dbus_addr = 32'h0;
   logic [31:0] dbus_data = 32'h0;
   logic        flush = 1'b0;
   logic        pipe_hold = 1'b0;
   logic        dbus_stall;
   logic [31:0] dbus_rdata;
   logic        addr_err;
   logic        sram_req;
   logic        sram_wr;
   logic [1:0]  sram_size;
   logic [31:0] sram_addr;
   logic [3:0]  sram_wstrb;
   logic [31:0] sram_wdata;
   logic        sram_addr_ok = 1'b0;
   logic        sram_data_ok = 1'b0;
   logic [31:0] sram_rdata = 32'h0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   dbus_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dbus_en      (dbus_en),
      .dbus_we      (dbus_we),
      .dbus_size    (dbus_size),
      .dbus_addr    (dbus_addr),
      .dbus_data    (dbus_data),
      .flush        (flush),
      .pipe_hold    (pipe_hold),
      .dbus_stall   (dbus_stall),
      .dbus_rdata   (dbus_rdata),
      .addr_err     (addr_err),
      .sram_req     (sram_req),
      .sram_wr      (sram_wr),
      .sram_size    (sram_size),
      .sram_addr    (sram_addr),
      .sram_wstrb   (sram_wstrb),
      .sram_wdata   (sram_wdata),
      .sram_addr_ok (sram_addr_ok),
      .sram_data_ok (sram_data_ok),
      .sram_rdata   (sram_rdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit misal(input logic [1:0] sz, input logic [31:0] a);
`ifdef DBUS_ALIGN_CHECK_EN
      int bytes;
      bytes = 1 << sz;
      return (sz != 2'b11) && ((a % bytes) != 0);
`else
      return (sz != sz) || (a != a);
`endif
   endfunction

   function automatic logic [3:0] exp_strb(input logic we, input logic [1:0] sz, input logic [31:0] a);
      int bytes;
      int start;
      bytes = 1 << sz;
      start = int'(a % 4) - (int'(a % 4) % bytes);
      if (!we) return 4'b0000;
      return 4'(((1 << bytes) - 1) << start);
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
      int          bits;
      logic [63:0] unit;
      logic [31:0] r;
      bits = 8 << sz;
      unit = {32'h0, d} & ((64'd1 << bits) - 64'd1);
      r = 32'h0;
      for (int k = 0; k < 32; k += bits) r |= 32'(unit << k);
      return r;
   endfunction

   // Transaction-level reference: pending request, awaited data, dropped access, held result.
   bit          m_on = 1'b0;
   bit          m_pend = 1'b0;
   bit          m_wait = 1'b0;
   bit          m_drop = 1'b0;
   bit          m_res = 1'b0;
   logic        t_we;
   logic [1:0]  t_size;
   logic [31:0] t_addr;
   logic [31:0] t_data;
   logic [31:0] m_rdata = 32'h0;
   bit          e_idle;
   bit          e_take;

   always @(negedge clk) begin
      if (m_on) begin
         e_idle = !(m_pend || m_wait || m_res);
         e_take = e_idle && dbus_en && !flush && !misal(dbus_size, dbus_addr);
         chk("stall", dbus_stall, e_take || m_pend || m_wait);
         chk("req", sram_req, m_pend);
         chk("addr_err", addr_err, e_idle && dbus_en && misal(dbus_size, dbus_addr));
         if (m_pend) begin
            chk("wr", sram_wr, t_we);
            chk("size", sram_size, t_size);
            chk("addr", sram_addr, t_addr);
            chk("wstrb", sram_wstrb, exp_strb(t_we, t_size, t_addr));
            if (t_we) chk("wdata", sram_wdata, exp_wdata(t_size, t_data));
         end
         if (m_res) chk("rdata", dbus_rdata, m_rdata);

         if (e_idle) begin
            if (e_take) begin
               t_we   = dbus_we;
               t_size = dbus_size;
               t_addr = dbus_addr;
               t_data = dbus_data;
               m_pend = 1'b1;
            end
         end else if (m_pend) begin
            if (sram_addr_ok) begin
               m_pend = 1'b0;
               if (sram_data_ok) begin
                  if (!flush) begin
                     m_res   = 1'b1;
                     m_rdata = sram_rdata;
                  end
               end else begin
                  m_wait = 1'b1;
                  m_drop = flush;
               end
            end else if (flush) begin
               m_pend = 1'b0;
            end
         end else if (m_wait) begin
            if (sram_data_ok) begin
               m_wait = 1'b0;
               if (!(m_drop || flush)) begin
                  m_res   = 1'b1;
                  m_rdata = sram_rdata;
               end
               m_drop = 1'b0;
            end else if (flush) begin
               m_drop = 1'b1;
            end
         end else if (!pipe_hold || flush) begin
            m_res = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_stall", dbus_stall, 0);
      chk("rst_req", sram_req, 0);
      chk("rst_wr", sram_wr, 0);
      chk("rst_size", sram_size, 0);
      chk("rst_addr", sram_addr, 0);
      chk("rst_wstrb", sram_wstrb, 0);
      chk("rst_wdata", sram_wdata, 0);
      chk("rst_rdata", dbus_rdata, 0);
      chk("rst_addr_err", addr_err, 0);
      step();
      rst_n = 1'b1;
      m_on  = 1'b1;

      // Word load, same-cycle accept and data
      dbus_en = 1; dbus_we = 0; dbus_size = 2'b10; dbus_addr = 32'h100;
      @(negedge clk); chk("t1_stall_cap", dbus_stall, 1); chk("t1_req_cap", sram_req, 0);
      step(); sram_addr_ok = 1; sram_data_ok = 1; sram_rdata = 32'hDEADBEEF;
      @(negedge clk); chk("t1_stall_addr", dbus_stall, 1); chk("t1_req", sram_req, 1);
      chk("t1_addr", sram_addr, 32'h100); chk("t1_wstrb", sram_wstrb, 0);
      step(); sram_addr_ok = 0; sram_data_ok = 0;
      @(negedge clk); chk("t1_stall_done", dbus_stall, 0); chk("t1_rdata", dbus_rdata, 32'hDEADBEEF);
      step(); dbus_en = 0;
      @(negedge clk); chk("t1_idle_req", sram_req, 0); chk("t1_idle_stall", dbus_stall, 0);
      step();

      // Byte store to the top lane
      dbus_en = 1; dbus_we = 1; dbus_size = 2'b00; dbus_addr = 32'h103; dbus_data = 32'hAB;
      step(); sram_addr_ok = 1;
      @(negedge clk); chk("t2_req", sram_req, 1); chk("t2_wr", sram_wr, 1);
      chk("t2_wstrb", sram_wstrb, 4'b1000); chk("t2_wdata", sram_wdata, 32'hABABABAB);
      step(); sram_addr_ok = 0;
      @(negedge clk); chk("t2_req_data", sram_req, 0); chk("t2_stall_data", dbus_stall, 1);
      step(); sram_data_ok = 1; sram_rdata = 32'h0;
      @(negedge clk); chk("t2_stall_dok", dbus_stall, 1);
      step(); sram_data_ok = 0;
      @(negedge clk); chk("t2_stall_done", dbus_stall, 0);
      step(); dbus_en = 0; dbus_we = 0;
      step();

      // Delayed accept: request held stable while the MM inputs wander
      dbus_en = 1; dbus_we = 1; dbus_size = 2'b10; dbus_addr = 32'h200; dbus_data = 32'h12345678;
      step(); dbus_addr = 32'hFFFF_FFF0; dbus_data = 32'h0;
      for (int i = 0; i < 4; i++) begin
         sram_addr_ok = (i == 3);
         @(negedge clk);
         chk("t3_req", sram_req, 1); chk("t3_addr", sram_addr, 32'h200);
         chk("t3_wdata", sram_wdata, 32'h12345678); chk("t3_wstrb", sram_wstrb, 4'hF);
         step();
      end
      sram_addr_ok = 0;
      @(negedge clk); chk("t3_req_fall", sram_req, 0);
      step(); sram_data_ok = 1;
      step(); sram_data_ok = 0;
      step(); dbus_en = 0; dbus_we = 0;
      step();

      // Flush while awaiting data: result dropped, stall held through drain
      dbus_en = 1; dbus_size = 2'b10; dbus_addr = 32'h300;
      step(); sram_addr_ok = 1; sram_data_ok = 1; sram_rdata = 32'h55AA55AA;
      step(); sram_addr_ok = 0; sram_data_ok = 0;
      @(negedge clk); chk("t4_rdata_first", dbus_rdata, 32'h55AA55AA);
      step(); dbus_en = 0;
      step(); dbus_en = 1; dbus_addr = 32'h304;
      step(); sram_addr_ok = 1;
      step(); sram_addr_ok = 0; flush = 1;
      @(negedge clk); chk("t4_stall_flush", dbus_stall, 1);
      step(); flush = 0; dbus_en = 1; dbus_addr = 32'h308;
      @(negedge clk); chk("t4_stall_drain", dbus_stall, 1); chk("t4_req_drain", sram_req, 0);
      step(); sram_data_ok = 1; sram_rdata = 32'hBAD0BAD0;
      @(negedge clk); chk("t4_stall_dok", dbus_stall, 1);
      step(); sram_data_ok = 0; dbus_en = 0;
      @(negedge clk); chk("t4_stall_idle", dbus_stall, 0); chk("t4_req_idle", sram_req, 0);
      chk("t4_rdata_kept", dbus_rdata, 32'h55AA55AA);
      step();

      // Flush in ADDR without accept, then flush in IDLE
      dbus_en = 1; dbus_addr = 32'h310;
      step(); flush = 1;
      @(negedge clk); chk("t4b_req", sram_req, 1);
      step(); flush = 0; dbus_en = 0;
      @(negedge clk); chk("t4b_req_drop", sram_req, 0); chk("t4b_stall_drop", dbus_stall, 0);
      step(); dbus_en = 1; flush = 1;
      @(negedge clk); chk("t4c_stall", dbus_stall, 0);
      step(); dbus_en = 0; flush = 0;
      @(negedge clk); chk("t4c_req", sram_req, 0);
      step();

      // Pipeline hold in DONE
      dbus_en = 1; dbus_we = 0; dbus_size = 2'b10; dbus_addr = 32'h400;
      step(); sram_addr_ok = 1; sram_data_ok = 1; sram_rdata = 32'hCAFEF00D;
      step(); sram_addr_ok = 0; sram_data_ok = 0; pipe_hold = 1; sram_rdata = 32'h11111111;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_req", sram_req, 0); chk("t5_stall", dbus_stall, 0);
         chk("t5_rdata", dbus_rdata, 32'hCAFEF00D);
         step();
      end
      pipe_hold = 0;
      @(negedge clk); chk("t5_rdata_last", dbus_rdata, 32'hCAFEF00D); chk("t5_req_last", sram_req, 0);
      step(); dbus_en = 0;
      @(negedge clk); chk("t5_idle_req", sram_req, 0); chk("t5_idle_stall", dbus_stall, 0);
      step();

      // Misaligned half load
      dbus_en = 1; dbus_we = 0; dbus_size = 2'b01; dbus_addr = 32'h101;
      @(negedge clk);
`ifdef DBUS_ALIGN_CHECK_EN
      chk("t6_addr_err", addr_err, 1); chk("t6_stall", dbus_stall, 0);
      step(); dbus_en = 0;
      @(negedge clk); chk("t6_no_req", sram_req, 0);
      step();
`else
      chk("t6_addr_err", addr_err, 0); chk("t6_stall", dbus_stall, 1);
      step(); sram_addr_ok = 1; sram_data_ok = 1; sram_rdata = 32'h0BAD_F00D;
      @(negedge clk); chk("t6_req", sram_req, 1); chk("t6_addr", sram_addr, 32'h101);
      step(); sram_addr_ok = 0; sram_data_ok = 0; dbus_en = 0;
      step();
`endif

      // Randomized traffic with a protocol-legal SRAM responder
      for (int n = 0; n < 3000; n++) begin
         dbus_en   = ($urandom_range(0, 9) < 6);
         dbus_we   = $urandom_range(0, 1);
         dbus_size = 2'($urandom_range(0, 2));
         dbus_addr = $urandom;
         dbus_data = $urandom;
         flush     = ($urandom_range(0, 9) == 0);
         pipe_hold = ($urandom_range(0, 9) < 3);
         sram_rdata = $urandom;
         sram_addr_ok = 0;
         sram_data_ok = 0;
         if (m_pend) begin
            sram_addr_ok = ($urandom_range(0, 1) == 1);
            sram_data_ok = sram_addr_ok && ($urandom_range(0, 9) < 3);
         end else if (m_wait) begin
            sram_data_ok = ($urandom_range(0, 9) < 4);
         end
         step();
      end

      dbus_en = 0; flush = 0; pipe_hold = 0; sram_addr_ok = 0; sram_data_ok = 0;
      repeat (2) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
